bram_accumulator: RTL and testbench



---
 rtl/bram_accumulator.sv | 67 ++++++
 tb/tb_bram_accumulator.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/bram_accumulator.sv
// Single-port block RAM with a read-accumulate datapath: each enabled read returns the word and adds it into sum.
// Define ACC_SAT_EN to saturate the accumulator at all-ones instead of wrapping modulo 2**DATA_W.
module bram_accumulator #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] sum,
  output logic              c_out
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W:0]   acc_p0;
  logic              wr_p0;
  logic              rd_p0;

  // Carry-extended accumulate; in the saturating build an overflow (or an
  // already-saturated accumulator) pins the result at all-ones with carry set.
  function automatic logic [DATA_W:0] acc_next(
    input logic [DATA_W-1:0] acc,
    input logic [DATA_W-1:0] word,
    input logic              carry_prev
  );
    logic [DATA_W:0] raw;
    raw = {1'b0, acc} + {1'b0, word};
`ifdef ACC_SAT_EN
    if (raw[DATA_W] || carry_prev)
      raw = {1'b1, {DATA_W{1'b1}}};
`else
    if (carry_prev) raw = raw;
`endif
    return raw;
  endfunction

  assign rd_word = mem[addr];
  assign wr_p0   = enable && write_en && !rst;
  assign rd_p0   = enable && !write_en;
  assign acc_p0  = acc_next(sum, rd_word, c_out);

  // Stage p0 -> registered outputs; memory is never cleared by rst.
  always_ff @(posedge clk) begin
    if (wr_p0)
      mem[addr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      sum      <= '0;
      c_out    <= 1'b0;
    end else if (rd_p0) begin
      data_out <= rd_word;
      sum      <= acc_p0[DATA_W-1:0];
      c_out    <= acc_p0[DATA_W];
    end
  end

endmodule

// File: tb/tb_bram_accumulator.sv
// Self-checking bench for bram_accumulator: directed vector table, then randomized traffic vs. a behavioural model.
module tb_bram_accumulator;

  logic       clk = 1'b0;
  logic       rst, enable, write_en;
  logic [3:0] addr;
  logic [7:0] data_in, data_out, sum;
  logic       c_out;

  int n_tests = 0;
  int n_fail  = 0;

  bram_accumulator #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .write_en(write_en), .addr(addr),
    .data_in(data_in), .data_out(data_out), .sum(sum), .c_out(c_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, en, we;
    logic [3:0] addr;
    logic [7:0] din, dout, sum;
    logic       cout;
  } vec_t;

  vec_t vecs[$];

  // behavioural model state
  int mem_m [16];
  int sum_m, dout_m, c_m;

  task automatic add(input logic r, e, w, input int a, d, o, s, c);
    vec_t v;
    v.rst = r; v.en = e; v.we = w; v.addr = 4'(a); v.din = 8'(d);
    v.dout = 8'(o); v.sum = 8'(s); v.cout = c[0];
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, e, w, input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    rst = r; enable = e;
    if (e) begin write_en = w; addr = a; data_in = d; end
    else begin write_en = 1'bx; addr = 'x; data_in = 'x; end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; write_en = 1'b0; addr = '0; data_in = '0;

    // reset and idle with X inputs
    add(1,0,0, 0,0,   0,0,0);
    for (int i = 0; i < 3; i++) add(0,0,0, 0,0, 0,0,0);
    // load 1..5 into addr 0..4, outputs hold
    for (int i = 0; i < 5; i++) add(0,1,1, i,i+1, 0,0,0);
    add(0,1,0, 4,0,   5,5,0);
    add(0,0,0, 0,0,   5,5,0);
    // sequential accumulate
    add(1,0,0, 0,0,   0,0,0);
    add(0,1,0, 0,0,   1,1,0);
    add(0,1,0, 1,0,   2,3,0);
    add(0,1,0, 2,0,   3,6,0);
    add(0,1,0, 3,0,   4,10,0);
    add(0,1,0, 4,0,   5,15,0);
    // overflow
    add(0,1,1, 5,200, 5,15,0);
    add(0,1,1, 6,100, 5,15,0);
    add(1,0,0, 0,0,   0,0,0);
    add(0,1,0, 5,0,   200,200,0);
`ifdef ACC_SAT_EN
    add(0,1,0, 6,0,   100,255,1);
    add(0,1,0, 0,0,   1,255,1);
`else
    add(0,1,0, 6,0,   100,44,1);
    add(0,1,0, 0,0,   1,45,0);
`endif
    // reset mid-operation beats a simultaneous write
    add(1,0,0, 0,0,   0,0,0);
    add(0,1,0, 2,0,   3,3,0);
    add(1,1,1, 2,9,   0,0,0);
    add(0,1,0, 2,0,   3,3,0);
    // write then read the same address
    add(0,1,1, 15,7,  3,3,0);
    add(0,1,0, 15,0,  7,10,0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].din);
      chk($sformatf("vec%0d data_out", i), int'(data_out), int'(vecs[i].dout));
      chk($sformatf("vec%0d sum", i),      int'(sum),      int'(vecs[i].sum));
      chk($sformatf("vec%0d c_out", i),    int'(c_out),    int'(vecs[i].cout));
    end

    // randomized phase: reset, fill every word, then mixed traffic
    drive(1, 0, 0, 0, 0);
    sum_m = 0; dout_m = 0; c_m = 0;
    for (int a = 0; a < 16; a++) begin
      mem_m[a] = int'($urandom_range(0, 255));
      drive(0, 1, 1, 4'(a), 8'(mem_m[a]));
    end
    for (int n = 0; n < 400; n++) begin
      logic r, e, w;
      logic [3:0] a;
      logic [7:0] d;
      int total;
      r = ($urandom_range(0, 19) == 0);
      e = ($urandom_range(0, 3) != 0);
      w = ($urandom_range(0, 2) == 0);
      a = 4'($urandom_range(0, 15));
      d = 8'($urandom_range(0, 255));
      drive(r, e, w, a, d);
      if (r) begin
        sum_m = 0; dout_m = 0; c_m = 0;
      end else if (e && w) begin
        mem_m[a] = d;
      end else if (e) begin
        dout_m = mem_m[a];
        total  = sum_m + mem_m[a];
`ifdef ACC_SAT_EN
        if (c_m == 1 || total > 255) begin sum_m = 255; c_m = 1; end
        else begin sum_m = total; c_m = 0; end
`else
        sum_m = total % 256;
        c_m   = (total > 255) ? 1 : 0;
`endif
      end
      chk($sformatf("rnd%0d data_out", n), int'(data_out), dout_m);
      chk($sformatf("rnd%0d sum", n),      int'(sum),      sum_m);
      chk($sformatf("rnd%0d c_out", n),    int'(c_out),    c_m);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
